// File: rtl/addr8s_result_checker.sv
// addr8s_result_checker: handshake wrapper that drives an 8-bit signed adder, checks its result and counts errors.
// Optional ADDR8S_CHK_CORRECT_EN: return the golden sum in place of a mismatching adder result.
module addr8s_result_checker #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic [7:0]       dut_a,
    output logic [7:0]       dut_b,
    input  logic [8:0]       dut_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_sum,
    output logic             out_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [1:0] state;
    logic [3:0] cnt;
    logic [8:0] golden;
    logic [8:0] sum_sel;
    logic       mismatch;
    logic       capture;

    assign golden   = {dut_a[7], dut_a} + {dut_b[7], dut_b};
    assign mismatch = dut_o != golden;
    assign capture  = state == DRIVE && cnt == 4'd0;
`ifdef ADDR8S_CHK_CORRECT_EN
    assign sum_sel = mismatch ? golden : dut_o;
`else
    assign sum_sel = dut_o;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dut_a     <= 8'd0;
            dut_b     <= 8'd0;
            out_sum   <= 9'd0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    dut_a    <= a;
                    dut_b    <= b;
                    cnt      <= 4'(SETTLE - 1);
                    in_ready <= 1'b0;
                    state    <= DRIVE;
                end
                DRIVE: if (cnt == 4'd0) begin
                    out_sum   <= sum_sel;
                    out_err   <= mismatch;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // clr wins over a same-edge capture; counters saturate instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt    <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            txn_cnt    <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (capture) begin
            txn_cnt <= txn_cnt == MAX ? txn_cnt : txn_cnt + 1'b1;
            if (mismatch) begin
                err_cnt    <= err_cnt == MAX ? err_cnt : err_cnt + 1'b1;
                err_sticky <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_addr8s_result_checker.sv
// tb_addr8s_result_checker: scoreboard bench with a behavioural adder (optionally O[0] stuck-at-1).
module tb_addr8s_result_checker;
    localparam int S  = 3;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef ADDR8S_CHK_CORRECT_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_err, err_sticky, clr, fault;
    logic [7:0] a, b, dut_a, dut_b;
    logic [8:0] dut_o, out_sum, add_res;
    logic [CW-1:0] txn_cnt, err_cnt;
    int errors = 0, checks = 0;
    int mt = 0, me = 0;
    bit st = 0;
    logic [9:0] q[$];

    addr8s_result_checker #(.SETTLE(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .dut_a(dut_a), .dut_b(dut_b), .dut_o(dut_o), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err(out_err), .err_sticky(err_sticky), .txn_cnt(txn_cnt),
        .err_cnt(err_cnt), .clr(clr)
    );

    assign add_res = 9'($signed(dut_a) + $signed(dut_b));
    assign dut_o   = fault ? (add_res | 9'd1) : add_res;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input bit f);
        int g;
        logic [8:0] gs, act;
        g   = int'($signed(x)) + int'($signed(y));
        gs  = 9'(g);
        act = f ? (gs | 9'd1) : gs;
        return {act != gs, CORR ? gs : act};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) chk("scoreboard_empty", 1, 0);
            else begin
                logic [9:0] e;
                e = q.pop_front();
                chk("out_sum", int'(out_sum), int'(e[8:0]));
                chk("out_err", int'(out_err), int'(e[9]));
            end
        end
    end

    task automatic run_txn(input logic [7:0] x, input logic [7:0] y, input bit f, input int hold, input bit cc);
        int n;
        logic [9:0] e;
        logic [8:0] s0;
        fault = f; a = x; b = y; in_valid = 1; n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("accept_wait", int'(in_ready), 1);
        tick();
        in_valid = 0;
        e = model(x, y, f);
        q.push_back(e);
        n = 0;
        while (!out_valid && n < 50) begin
            clr = cc && n == S - 1;
            tick();
            n++;
        end
        clr = 0;
        chk("latency", n, S);
        if (cc) begin mt = 0; me = 0; st = 0; end
        else begin
            mt = mt < CMAX ? mt + 1 : mt;
            if (e[9]) begin me = me < CMAX ? me + 1 : me; st = 1; end
        end
        chk("txn_cnt", int'(txn_cnt), mt);
        chk("err_cnt", int'(err_cnt), me);
        chk("err_sticky", int'(err_sticky), int'(st));
        chk("dut_a", int'(dut_a), int'(x));
        s0 = out_sum;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1; a = ~x;
            tick();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_sum", int'(out_sum), int'(s0));
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_dut_a", int'(dut_a), int'(x));
        end
        in_valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        rst = 1; in_valid = 0; out_ready = 0; clr = 0; fault = 0; a = 0; b = 0;
        tick(); tick();
        rst = 0;
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_dut_a", int'(dut_a), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_txn_cnt", int'(txn_cnt), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_err_sticky", int'(err_sticky), 0);

        run_txn(8'h7F, 8'h7F, 0, 0, 0);
        run_txn(8'h80, 8'h80, 0, 0, 0);
        run_txn(8'h05, 8'hFD, 0, 0, 0);
        run_txn(8'h02, 8'h02, 1, 0, 0);
        run_txn(8'h10, 8'h21, 0, 5, 0);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = 8'($urandom);
            y[0] = x[0];
            run_txn(x, y, 1, 0, 0);
        end
        run_txn(8'h04, 8'h06, 1, 0, 1);
        for (int i = 0; i < 30; i++)
            run_txn(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 0);

        clr = 1; tick(); clr = 0; mt = 0; me = 0; st = 0;
        fault = 0; a = 8'h11; b = 8'h22; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        #1 rst = 1;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_dut_a", int'(dut_a), 0);
        chk("arst_dut_b", int'(dut_b), 0);
        chk("arst_out_sum", int'(out_sum), 0);
        chk("arst_out_err", int'(out_err), 0);
        chk("arst_txn_cnt", int'(txn_cnt), 0);
        #1 rst = 0;
        tick(); tick();
        chk("post_rst_txn_cnt", int'(txn_cnt), 0);
        chk("post_rst_out_valid", int'(out_valid), 0);
        run_txn(8'hFF, 8'h01, 0, 1, 0);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
